onehot_dec_seq: RTL and testbench

ONEHOT_DEC_SEQ -- requirements
Module: onehot_dec_seq

---
 rtl/onehot_dec_pkg.sv | 23 ++
 rtl/onehot_dec_seq_if.sv | 28 ++
 rtl/onehot_scan_prescaler.sv | 33 +++
 rtl/onehot_dec_seq.sv | 122 ++++++++++++
 tb/tb_onehot_dec_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types for the one-hot decoder / scanner.
// Build option: define ONEHOT_DEC_SCAN_EN to include the auto-scan state.
package onehot_dec_pkg;

`ifdef ONEHOT_DEC_SCAN_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1
  } state_e;
`endif

  // Counter width able to hold 0..div-1; never below one bit.
  function automatic int unsigned cnt_width(int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/onehot_dec_seq_if.sv
// Handshake and output bundle of the one-hot decoder.
// master drives the code/control side, slave is the decoder itself.
interface onehot_dec_seq_if #(
  parameter int unsigned W     = 2,
  parameter int unsigned N_OUT = 3
) ();

  logic             en;
  logic             mode;
  logic [W-1:0]     x;
  logic             x_valid;
  logic             x_ready;
  logic [N_OUT-1:0] y;
  logic             y_valid;
  logic [W-1:0]     idx;
  logic             err;

  modport master (
    output en, mode, x, x_valid,
    input  x_ready, y, y_valid, idx, err
  );

  modport slave (
    input  en, mode, x, x_valid,
    output x_ready, y, y_valid, idx, err
  );

endinterface

// File: rtl/onehot_scan_prescaler.sv
// Scan dwell prescaler: free-running 0..DIV-1 counter with a terminal-count flag.
// Only instantiated when ONEHOT_DEC_SCAN_EN is defined.
module onehot_scan_prescaler
  import onehot_dec_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Count enabled clocks, wrapping at DIV-1; clr wins over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tc = (cnt_q == Last);

endmodule

// File: rtl/onehot_dec_seq.sv
// Registered binary-to-one-hot decoder with optional auto-scan.
// Build option: ONEHOT_DEC_SCAN_EN adds the scan state and prescaler; without it
// mode is ignored and every enabled cycle accepts a code.
module onehot_dec_seq
  import onehot_dec_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned DIV   = 4
) (
  input logic               clk,
  input logic               rst_n,
  onehot_dec_seq_if.slave   bus
);

  state_e           state_q;
  logic [N_OUT-1:0] y_q;
  logic [W-1:0]     idx_q;
  logic             y_valid_q;
  logic             err_q;

  logic mode_eff;
  logic xfer;
  logic in_range;

  function automatic logic [N_OUT-1:0] dec(logic [W-1:0] code);
    return N_OUT'(1) << code;
  endfunction

`ifdef ONEHOT_DEC_SCAN_EN
  logic         scan_tc;
  logic         pre_clr;
  logic         pre_en;
  logic [W-1:0] scan_next;

  assign mode_eff = bus.mode;

  // Counter restarts on scan entry and only runs while actually scanning.
  assign pre_clr = bus.en & mode_eff & (state_q != StScan);
  assign pre_en  = bus.en & mode_eff & (state_q == StScan);

  onehot_scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .en    (pre_en),
    .tc    (scan_tc)
  );

  assign scan_next = (idx_q == W'(N_OUT - 1)) ? '0 : idx_q + W'(1);
`else
  assign mode_eff = 1'b0;

  // Scan-only configuration and the idle/direct distinction have no consumer here.
  logic unused_cfg;
  assign unused_cfg = ^{DIV, bus.mode, state_q};
`endif

  assign bus.x_ready = bus.en & ~mode_eff;
  assign xfer        = bus.x_valid & bus.x_ready;
  assign in_range    = (32'(bus.x) < N_OUT);

  // Control FSM with registered outputs; en low freezes everything but the pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_q       <= '0;
      idx_q     <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
      if (bus.en) begin
`ifdef ONEHOT_DEC_SCAN_EN
        if (mode_eff && (state_q != StScan)) begin
          state_q   <= StScan;
          idx_q     <= '0;
          y_q       <= dec('0);
          y_valid_q <= 1'b1;
        end else if (!mode_eff && (state_q == StScan)) begin
          // Leave scan quietly, keeping the last scanned value.
          state_q <= StDirect;
        end else if (state_q == StScan) begin
          if (scan_tc) begin
            idx_q     <= scan_next;
            y_q       <= dec(scan_next);
            y_valid_q <= 1'b1;
          end
        end else
`endif
        if (xfer) begin
          state_q   <= StDirect;
          y_valid_q <= 1'b1;
          if (in_range) begin
            y_q   <= dec(bus.x);
            idx_q <= bus.x;
          end else begin
            y_q   <= '0;
            idx_q <= '0;
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.idx     = idx_q;
  assign bus.y_valid = y_valid_q;
  assign bus.err     = err_q;

  // y is one-hot or empty, and idx always names the asserted bit.
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.y));
  a_idx_zero: assert property (@(posedge clk) disable iff (!rst_n)
                               (bus.y == '0) |-> (bus.idx == '0));
  a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
                                (bus.y != '0) |-> (bus.y == dec(bus.idx)));

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Scoreboard bench for onehot_dec_seq: a time-based reference model predicts every
// y_valid event; a negedge monitor pops and compares, plus checks held outputs.
module tb_onehot_dec_seq;

  localparam int unsigned W     = 2;
  localparam int unsigned N_OUT = 3;
  localparam int unsigned DIV   = 4;

  typedef struct {
    int unsigned      at;
    logic [N_OUT-1:0] y;
    logic [W-1:0]     idx;
    logic             err;
  } exp_t;

  logic clk;
  logic rst_n;

  onehot_dec_seq_if #(.W(W), .N_OUT(N_OUT)) bus ();

  onehot_dec_seq #(
    .W     (W),
    .N_OUT (N_OUT),
    .DIV   (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  bit          mon_on  = 1'b0;
  exp_t        q[$];

  // Reference state: value on the outputs and elapsed scan time.
  bit               m_scan = 1'b0;
  int unsigned      m_t    = 0;
  int unsigned      m_idx  = 0;
  logic [N_OUT-1:0] m_y    = '0;

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(bit e);
    exp_t ev;
    ev.at  = cyc;
    ev.y   = m_y;
    ev.idx = W'(m_idx);
    ev.err = e;
    q.push_back(ev);
  endtask

  // Reference model, evaluated on each rising edge from the inputs the DUT samples.
  always @(posedge clk) begin
    bit m_mode;
    cyc++;
`ifdef ONEHOT_DEC_SCAN_EN
    m_mode = bus.mode;
`else
    m_mode = 1'b0;
`endif
    if (!rst_n) begin
      m_scan = 1'b0;
      m_t    = 0;
      m_idx  = 0;
      m_y    = '0;
    end else if (!bus.en) begin
      chk("x_ready_disabled", 32'(bus.x_ready), 0);
    end else begin
      chk("x_ready", 32'(bus.x_ready), 32'(!m_mode));
      if (m_mode && !m_scan) begin
        m_scan = 1'b1;
        m_t    = 0;
        m_idx  = 0;
        m_y    = N_OUT'(1);
        push(1'b0);
      end else if (m_scan && !m_mode) begin
        m_scan = 1'b0;
      end else if (m_scan) begin
        m_t++;
        if (m_t % DIV == 0) begin
          m_idx = (m_t / DIV) % N_OUT;
          m_y   = N_OUT'(1 << m_idx);
          push(1'b0);
        end
      end else if (bus.x_valid) begin
        if (32'(bus.x) < N_OUT) begin
          m_idx = 32'(bus.x);
          m_y   = N_OUT'(1 << m_idx);
          push(1'b0);
        end else begin
          m_idx = 0;
          m_y   = '0;
          push(1'b1);
        end
      end
    end
  end

  // Monitor: compare DUT outputs half a cycle after each edge.
  always @(negedge clk) begin
    if (mon_on) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        exp_t lost;
        lost = q.pop_front();
        chk("missed_pulse", 32'(lost.at), cyc);
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        exp_t ev;
        ev = q.pop_front();
        chk("y_valid", 32'(bus.y_valid), 1);
        chk("pulse_y", 32'(bus.y), 32'(ev.y));
        chk("pulse_idx", 32'(bus.idx), 32'(ev.idx));
        chk("pulse_err", 32'(bus.err), 32'(ev.err));
      end else begin
        chk("no_y_valid", 32'(bus.y_valid), 0);
        chk("no_err", 32'(bus.err), 0);
      end
      chk("held_y", 32'(bus.y), 32'(m_y));
      chk("held_idx", 32'(bus.idx), m_idx);
    end
  end

  task automatic step(bit r, bit e, bit m, logic [W-1:0] xv, bit v);
    @(negedge clk);
    rst_n       = r;
    bus.en      = e;
    bus.mode    = m;
    bus.x       = xv;
    bus.x_valid = v;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.mode    = 1'b0;
    bus.x       = '0;
    bus.x_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b1;
    // Reset values hold with rst_n low while en and a code are offered.
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    // Direct decode of 1, then hold.
    step(1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    // Out-of-range code.
    step(1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
    // Scan for 14 clocks with data offered (ignored), then drop back.
    repeat (14) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    // Freeze mid-dwell on the second scan position, then resume.
    repeat (6) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    // Reset mid-scan with a code offered.
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    // mode high with a valid code: a transfer only when scan is compiled out.
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    // Random traffic with sticky mode.
    begin
      bit m;
      m = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 19) == 0) m = ~m;
        step(($urandom_range(0, 99) != 0), ($urandom_range(0, 6) != 0), m,
             W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
